// File: rtl/alu_exec_pkg.sv
// Shared types and constants for the alu_exec block and its iterative multiplier.
// The optional multiplier is enabled by defining ALU_EXEC_MUL_EN.
package alu_exec_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned IMM_W     = 5;
  localparam int unsigned MUL_ITERS = 16;
  localparam int unsigned CNT_W     = $clog2(MUL_ITERS);

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_AND   = 2'b01,
    ALU_NOT   = 2'b10,
    ALU_PASSA = 2'b11
  } alu_op_e;

  // Opcode 11 doubles as MUL when the multiplier is built in.
  localparam alu_op_e ALU_MUL = ALU_PASSA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_MUL  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  typedef struct packed {
    alu_op_e             op;
    logic                ld_cc;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
  } alu_req_t;

  typedef struct packed {
    logic n;
    logic z;
    logic p;
  } cc_t;

  localparam cc_t CC_RESET = 3'b010;

  function automatic logic [DATA_W-1:0] sext_imm5(input logic [IMM_W-1:0] imm);
    return {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

  function automatic cc_t cc_of(input logic [DATA_W-1:0] r);
    cc_t cc;
    cc.n = r[DATA_W-1];
    cc.z = (r == '0);
    cc.p = !r[DATA_W-1] && (r != '0);
    return cc;
  endfunction

  function automatic logic [DATA_W-1:0] alu_compute(input alu_op_e op,
                                                    input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (op)
      ALU_ADD: r = a + b;
      ALU_AND: r = a & b;
      ALU_NOT: r = ~a;
      default: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mul16_iter.sv
// Iterative shift-add multiplier: low DATA_W bits of a*b over MUL_ITERS cycles.
// Instantiated by alu_exec only when ALU_EXEC_MUL_EN is defined.
module mul16_iter
  import alu_exec_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              done_c,
  output logic [DATA_W-1:0] product_c
);

  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [DATA_W-1:0] step_c;

  // product_c is the accumulator after the current step, so the last step's
  // result is visible in the same cycle done_c is high.
  always_comb begin
    step_c    = mplier_q[0] ? mcand_q : '0;
    product_c = acc_q + step_c;
    done_c    = busy_q && (cnt_q == CNT_W'(MUL_ITERS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= a_i;
      mplier_q <= b_i;
    end else if (busy_q) begin
      acc_q    <= product_c;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
      if (done_c) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Multi-cycle ALU execute stage with condition codes; ALUK=11 is PASSA by default,
// or an iterative MUL when ALU_EXEC_MUL_EN is defined.
module alu_exec
  import alu_exec_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [1:0]        ALUK,
  input  logic              SR2MUX,
  input  logic [IMM_W-1:0]  imm5,
  input  logic [DATA_W-1:0] SR1OUT,
  input  logic [DATA_W-1:0] SR2OUT,
  input  logic              LD_CC,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] ALU_OUT,
  output logic              N,
  output logic              Z,
  output logic              P
);

  state_e            state_q, state_d;
  alu_req_t          req_q, req_d;
  logic [DATA_W-1:0] alu_out_q, alu_out_d;
  cc_t               cc_q, cc_d;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] b_sel_c;
  logic [DATA_W-1:0] result_c;

  assign b_sel_c = SR2MUX ? sext_imm5(imm5) : SR2OUT;

`ifdef ALU_EXEC_MUL_EN
  logic              mul_start_c;
  logic              mul_done_c;
  logic [DATA_W-1:0] mul_product_c;

  mul16_iter u_mul (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .start_i   (mul_start_c),
    .a_i       (SR1OUT),
    .b_i       (b_sel_c),
    .done_c    (mul_done_c),
    .product_c (mul_product_c)
  );
`endif

  // Next-state and datapath updates; operands are captured only on accept.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    alu_out_d = alu_out_q;
    cc_d      = cc_q;
    result_c  = alu_compute(req_q.op, req_q.a, req_q.b);
`ifdef ALU_EXEC_MUL_EN
    mul_start_c = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          req_d.op    = alu_op_e'(ALUK);
          req_d.ld_cc = LD_CC;
          req_d.a     = SR1OUT;
          req_d.b     = b_sel_c;
`ifdef ALU_EXEC_MUL_EN
          if (alu_op_e'(ALUK) == ALU_MUL) begin
            state_d     = ST_MUL;
            mul_start_c = 1'b1;
          end else begin
            state_d = ST_EXEC;
          end
`else
          state_d = ST_EXEC;
`endif
        end
      end
      ST_EXEC: begin
        alu_out_d = result_c;
        if (req_q.ld_cc) begin
          cc_d = cc_of(result_c);
        end
        state_d = ST_DONE;
      end
`ifdef ALU_EXEC_MUL_EN
      ST_MUL: begin
        if (mul_done_c) begin
          alu_out_d = mul_product_c;
          if (req_q.ld_cc) begin
            cc_d = cc_of(mul_product_c);
          end
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      alu_out_q <= '0;
      cc_q      <= CC_RESET;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      alu_out_q <= alu_out_d;
      cc_q      <= cc_d;
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ALU_OUT = alu_out_q;
  assign N       = cc_q.n;
  assign Z       = cc_q.z;
  assign P       = cc_q.p;

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have port Clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port start  input  1  request to begin one operation; sampled only in IDLE.
REQ-004 SHALL have port ALUK  input  2  opcode: 00 ADD, 01 AND, 10 NOT, 11 PASSA (MUL when MUL_EN defined).
REQ-005 SHALL have port SR2MUX  input  1  operand B select: 0 SR2OUT, 1 sign-extended imm5.
REQ-006 SHALL have port imm5  input  5  immediate field from IR.
REQ-007 SHALL have port SR1OUT  input  16  operand A from register file.
REQ-008 SHALL have port SR2OUT  input  16  operand B from register file.
REQ-009 SHALL have port LD_CC  input  1  update condition codes on completion of this operation.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse; ALU_OUT valid for register-file BUS load.
REQ-012 SHALL have port ALU_OUT  output  16  result register.
REQ-013 SHALL have ports N, Z, P  output  1 each  condition-code flags.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, MUL, DONE; IDLE->EXEC on start, EXEC->DONE, MUL->DONE after 16 iterations, DONE->IDLE unconditionally.
REQ-015 SHALL latch ALUK, LD_CC, operand A and selected operand B in the cycle start is accepted (cycle t); later input changes SHALL NOT affect the operation.
REQ-016 SHALL ignore start while busy=1; no queuing.
REQ-017 SHALL sign-extend imm5 bit 4 into bits 15:5 of operand B.
REQ-018 ADD SHALL compute A+B modulo 2^16, carry discarded; AND bitwise A&B; NOT bitwise ~A; PASSA A.
REQ-019 Single-cycle ops SHALL load ALU_OUT at end of cycle t+1 and assert done during cycle t+2 (latency 2).
REQ-020 done SHALL be high for exactly one cycle per accepted operation, only in DONE.
REQ-021 ALU_OUT SHALL hold its value between completions.
REQ-022 When latched LD_CC=1, N/Z/P SHALL update together with ALU_OUT: N=result[15], Z=(result==0), P otherwise; exactly one flag high at all times.
REQ-023 When latched LD_CC=0, N/Z/P SHALL be unchanged.
REQ-024 start asserted in the DONE cycle SHALL be ignored; next accept earliest at t+3.

Reset
REQ-025 Reset_n low SHALL immediately force IDLE, busy=0, done=0, ALU_OUT=16'h0000, N=0, Z=1, P=0.
REQ-026 Reset mid-operation SHALL abort it: no done pulse, no ALU_OUT or flag update.
REQ-027 First accept after release SHALL be on the first rising edge with Reset_n high.

Configuration
REQ-028 Macro ALU_EXEC_MUL_EN defined: ALUK=11 SHALL be MUL, IDLE->MUL, 16-cycle shift-add, ALU_OUT = low 16 bits of A*B, done at cycle t+17.
REQ-029 Macro undefined: ALUK=11 SHALL be PASSA with latency 2, MUL state and multiplier logic absent.

Structure
REQ-030 Package alu_exec_pkg SHALL hold the ALUK opcode enum, FSM state enum, data width 16, and MUL iteration count 16.
REQ-031 Iterative multiplier SHALL be sub-module mul16_iter (start/done, 16-bit operands, 16-bit product), instantiated only under ALU_EXEC_MUL_EN.

Verification
REQ-032 ADD A=16'h7FFF, SR2MUX=1, imm5=5'b00001, LD_CC=1 -> ALU_OUT=16'h8000, N=1, done at t+2.
REQ-033 ADD A=16'h0003, imm5=5'b11101 (-3), LD_CC=1 -> ALU_OUT=16'h0000, Z=1.
REQ-034 NOT A=16'h00FF, LD_CC=0 after prior Z=1 -> ALU_OUT=16'hFF00, flags remain Z=1.
REQ-035 AND A=16'hF0F0, SR2OUT=16'h3C3C with start held high through DONE -> single done, ALU_OUT=16'h3030, second op accepted at t+3.
REQ-036 MUL_EN: A=16'h0012, B=16'h0034 -> ALU_OUT=16'h03A8 at t+17; Reset_n pulsed low at t+8 -> no done, ALU_OUT=0, Z=1.
REQ-037 MUL_EN undefined: ALUK=11, A=16'hABCD -> ALU_OUT=16'hABCD at t+2.
